fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the architectural fetch PC and drives the instruction-memory request port. It applies next-PC redirects computed by the NPC logic for taken branches, `jal` and `jalr`, and keeps one fetch request outstanding at a time. Returned instructions are handed to decode through a valid/ready handshake. It sits between the NPC unit, instruction memory and the decode stage.

---
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one instruction-memory
// request in flight, applies NPC redirects and hands instructions to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;

    logic        grant_hit;
    logic        data_hit;
    logic        hand_off;

    // A grant that coincides with a redirect is wrong-path and does not advance the PC.
    assign grant_hit = (state == REQ)  && imem_gnt;
    assign data_hit  = (state == WAIT) && imem_rvalid && !redirect;
    assign hand_off  = (state == OUT)  && (if_ready || redirect);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (redirect) begin
                    state_nxt = imem_gnt ? DRAIN : REQ;
                end else if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_nxt = imem_rvalid ? REQ : DRAIN;
                end else if (imem_rvalid) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (redirect || if_ready) begin
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, never the inputs.
    always_comb begin
        imem_req  = (state == REQ);
        if_valid  = (state == OUT);
        imem_addr = fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0000_0000;
            if_pc    <= 32'h0000_0000;
            if_inst  <= NOP_INST;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (grant_hit) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (grant_hit && !redirect) begin
                req_pc <= fetch_pc;
            end

            if (data_hit) begin
                if_pc   <= req_pc;
                if_inst <= imem_rdata;
            end else if (hand_off) begin
                if_inst <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a scoreboard queue holds the instructions
// decode must see, filled when memory returns data and drained on if_valid.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, redirect, imem_gnt, imem_rvalid, if_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_pc, if_inst;

    logic        rst_b, redirect_b, imem_gnt_b, imem_rvalid_b, if_ready_b;
    logic [31:0] redirect_pc_b, imem_rdata_b;
    logic        imem_req_b, if_valid_b;
    logic [31:0] imem_addr_b, if_pc_b, if_inst_b;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   valid_cyc = 0;

    fetch_ctrl u_dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_gnt(imem_gnt_b),
        .imem_rvalid(imem_rvalid_b), .imem_rdata(imem_rdata_b),
        .if_valid(if_valid_b), .if_pc(if_pc_b), .if_inst(if_inst_b), .if_ready(if_ready_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pop_check(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] inst);
        exp_t e;
        check({tag, "_valid"}, {31'd0, v}, 32'd1);
        check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_pc"}, pc, e.pc);
            check({tag, "_inst"}, inst, e.inst);
        end
        valid_cyc = cyc;
    endtask

    // Full fetch of addr on u_dut; decode stalls for `stall` OUT cycles.
    task automatic fetch(input logic [31:0] addr, input int stall);
        check("req", {31'd0, imem_req}, 32'd1);
        check("addr", imem_addr, addr);
        check("valid_in_req", {31'd0, if_valid}, 32'd0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("req_in_wait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = addr ^ KEY;
        if_ready    = (stall == 0);
        sb.push_back('{pc: addr, inst: addr ^ KEY});
        tick();
        imem_rvalid = 1'b0;
        pop_check("out", if_valid, if_pc, if_inst);
        for (int k = 1; k < stall; k++) begin
            tick();
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_pc", if_pc, addr);
            check("stall_inst", if_inst, addr ^ KEY);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        if_ready = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        rst_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; imem_gnt_b = 1'b0;
        imem_rvalid_b = 1'b0; imem_rdata_b = '0; if_ready_b = 1'b1;
        repeat (2) tick();

        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, NOP);

        // First request on the second cycle after reset release.
        rst = 1'b0;
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);

        // Zero-wait memory, decode always ready: 0, 4, 8 at one per 3 cycles.
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prev = valid_cyc;
            fetch(32'(i * 4), 0);
            if (i > 0) check("valid_period", 32'(valid_cyc - prev), 32'd3);
        end

        // Backpressure: 5 cycles of if_ready=0 in OUT.
        fetch(32'h0000_000C, 5);

        // Redirect in WAIT, killed response two cycles later.
        check("w_addr", imem_addr, 32'h0000_0010);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("drain_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("drain_valid", {31'd0, if_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("drain_exit_valid", {31'd0, if_valid}, 32'd0);
        check("drain_exit_inst", if_inst, NOP);
        fetch(32'h0000_0100, 0);

        // Redirect in REQ without grant, then redirect with grant at 0x8.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0008;
        tick();
        redirect = 1'b0;
        check("req_redir_req", {31'd0, imem_req}, 32'd1);
        check("req_redir_addr", imem_addr, 32'h0000_0008);
        imem_gnt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        check("gnt_redir_drain", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0008 ^ KEY;
        tick();
        imem_rvalid = 1'b0;
        check("gnt_redir_valid", {31'd0, if_valid}, 32'd0);
        fetch(32'h0000_0200, 0);

        // Redirect in OUT together with if_ready=1.
        check("o_addr", imem_addr, 32'h0000_0204);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0204 ^ KEY;
        sb.push_back('{pc: 32'h0000_0204, inst: 32'h0000_0204 ^ KEY});
        tick();
        imem_rvalid = 1'b0;
        pop_check("o_out", if_valid, if_pc, if_inst);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        check("o_redir_valid", {31'd0, if_valid}, 32'd0);
        check("o_redir_inst", if_inst, NOP);
        check("o_redir_req", {31'd0, imem_req}, 32'd1);
        check("o_redir_addr", imem_addr, 32'h0000_0300);

        // Redirect in WAIT with rvalid in the same cycle.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0400;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0300 ^ KEY;
        tick();
        redirect = 1'b0;
        imem_rvalid = 1'b0;
        check("wr_valid", {31'd0, if_valid}, 32'd0);
        check("wr_req", {31'd0, imem_req}, 32'd1);
        check("wr_addr", imem_addr, 32'h0000_0400);

        // Redirect in OUT while decode is stalled.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0400 ^ KEY;
        if_ready = 1'b0;
        sb.push_back('{pc: 32'h0000_0400, inst: 32'h0000_0400 ^ KEY});
        tick();
        imem_rvalid = 1'b0;
        pop_check("os_out", if_valid, if_pc, if_inst);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0500;
        tick();
        redirect = 1'b0;
        check("os_valid", {31'd0, if_valid}, 32'd0);
        check("os_addr", imem_addr, 32'h0000_0500);

        // RESET_PC = FFFF_FFFC: wrap to 0, then reset mid-WAIT.
        check("b_rst_addr", imem_addr_b, 32'hFFFF_FFFC);
        check("b_rst_req", {31'd0, imem_req_b}, 32'd0);
        rst_b = 1'b0;
        tick();
        check("b_req", {31'd0, imem_req_b}, 32'd1);
        check("b_addr0", imem_addr_b, 32'hFFFF_FFFC);
        imem_gnt_b = 1'b1;
        tick();
        imem_gnt_b = 1'b0;
        imem_rvalid_b = 1'b1;
        imem_rdata_b = 32'hFFFF_FFFC ^ KEY;
        sb.push_back('{pc: 32'hFFFF_FFFC, inst: 32'hFFFF_FFFC ^ KEY});
        tick();
        imem_rvalid_b = 1'b0;
        pop_check("b_out", if_valid_b, if_pc_b, if_inst_b);
        tick();
        check("b_wrap_req", {31'd0, imem_req_b}, 32'd1);
        check("b_wrap_addr", imem_addr_b, 32'h0000_0000);
        imem_gnt_b = 1'b1;
        tick();
        imem_gnt_b = 1'b0;
        rst_b = 1'b1;
        tick();
        check("b_mid_req", {31'd0, imem_req_b}, 32'd0);
        check("b_mid_addr", imem_addr_b, 32'hFFFF_FFFC);
        check("b_mid_valid", {31'd0, if_valid_b}, 32'd0);
        check("b_mid_pc", if_pc_b, 32'h0);
        check("b_mid_inst", if_inst_b, NOP);
        // Late response from the killed request arrives while in IDLE.
        rst_b = 1'b0;
        imem_rvalid_b = 1'b1;
        imem_rdata_b = 32'h0000_0000 ^ KEY;
        tick();
        imem_rvalid_b = 1'b0;
        check("b_late_req", {31'd0, imem_req_b}, 32'd1);
        check("b_late_addr", imem_addr_b, 32'hFFFF_FFFC);
        tick();
        check("b_late_valid", {31'd0, if_valid_b}, 32'd0);
        check("b_late_inst", if_inst_b, NOP);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
